sprite_palette_lut: RTL
=======================

// Module: sprite_palette_lut
// PURPOSE
//  Parametrised, run-time-writable colour palette for the sprite/VGA path.
//  Maps (palette select, pixel index) to RGB through a 2-stage registered pipeline.
//  Adds over a fixed ROM palette:
//   - NUM_PAL banks, rewritable during vblank
//   - transparent-index flag
//   - global fade-in/fade-out brightness FSM
//  Sits between the sprite ROM index output and the colour mapper.
// PARAMETERS
//  IDX_W      4   pixel index width; 2**IDX_W entries per bank
//  CH_W       4   bits per colour channel
//  NUM_PAL    4   number of palette banks (>=1); PAL_W = max(1,$clog2(NUM_PAL))
//  TRANSP_IDX 0   index flagged transparent in every bank
//  FADE_DIV   2   clocks per brightness step while fading (>=1)
// PORTS
//  Clk        in  1        clock, all state on rising edge
//  Reset_n    in  1        asynchronous active-low reset
//  pix_valid  in  1        lookup request this cycle
//  pix_pal    in  PAL_W    bank select for lookup
//  pix_idx    in  IDX_W    pixel index for lookup
//  out_valid  out 1        pix_valid delayed 2 clocks
//  red/green/blue out CH_W each  faded colour
//  transp     out 1        looked-up index == TRANSP_IDX
//  vblank     in  1        high = safe to rewrite palette
//  wr_valid   in  1        palette write request
//  wr_ready   out 1        = vblank (combinational); write accepted when wr_valid&wr_ready
//  wr_pal     in  PAL_W    bank to write
//  wr_idx     in  IDX_W    entry to write
//  wr_rgb     in  3*CH_W   {r,g,b} data
//  fade_start in  1        pulse: begin fade toward target given by fade_dir
//  fade_dir   in  1        1 = fade in to full, 0 = fade out to black
//  fade_busy  out 1        FSM in FADING
//  fade_done  out 1        one-clock pulse when target level reached
// BEHAVIOUR
//  Reset values:
//   - out_valid, rgb, transp, fade_busy, fade_done = 0
//   - level L = 2**CH_W (full brightness); fade FSM in IDLE
//   - every bank entry i: each channel = i zero-extended/truncated to CH_W (grey ramp)
//  Lookup pipeline:
//   - S1 registers bank[pix_pal][pix_idx], transp flag and valid
//   - S2 registers c_out = (c * L) >> CH_W per channel, flag and valid
//   - latency exactly 2; one lookup per clock; no backpressure
//   - invalid cycles still update datapath; ignore data when out_valid=0
//   - transp=1 forces rgb=0 in S2
//   - pix_pal >= NUM_PAL reads bank NUM_PAL-1
//  Write port:
//   - accepted write updates the entry at the next edge
//   - same-cycle read of the same entry returns OLD data (read-before-write)
//   - write while vblank=0 is not accepted; master must hold wr_valid until accepted
//   - wr_pal >= NUM_PAL: accepted and discarded
//  Fade FSM:
//   - states IDLE, FADING; L range 0..2**CH_W (width CH_W+1)
//   - IDLE + fade_start:
//     - L already equals target -> stay IDLE, fade_done pulses next clock
//     - else -> FADING, step counter cleared
//   - FADING: every FADE_DIV clocks, L += 1 (fade in) or L -= 1 (fade out)
//   - on reaching target -> IDLE, fade_done=1 for one clock
//   - fade_start while FADING: adopt new fade_dir, keep current L, restart step counter
//   - L saturates; never wraps
//   - L is sampled by S2, so a new L affects pixels in S2 at that edge
//  Reset_n low at any time:
//   - aborts fade and pipeline immediately
//   - restores grey-ramp banks
// TESTING
//  1 Reset, pix_idx=5, pal=0, valid -> out_valid at +2 clocks, rgb=5/5/5, transp=0.
//  2 vblank=1, write bank1 idx3 = F/0/8, then lookup pal1 idx3 -> rgb=F/0/8; same write with vblank=0 -> wr_ready=0, entry unchanged.
//  3 Same-cycle write and read of bank0 idx7 -> old 7/7/7 out, next read new value.
//  4 Lookup idx=TRANSP_IDX -> transp=1, rgb=0/0/0 at +2.
//  5 fade_start, dir=0, FADE_DIV=2 -> fade_busy for 32 clocks, fade_done pulse, entry F/F/F reads 0/0/0.
//    Mid-fade dir=1 restart from L=8 -> reaches 16 after 16 clocks.
//  6 Assert Reset_n low mid-fade with writes in flight -> all outputs 0, L=16, banks back to grey ramp.

Source files
------------

// File: rtl/sprite_palette_lut.sv
// Run-time writable sprite colour palette: banked LUT, transparent-index flag,
// two-stage registered lookup with a global fade-in/fade-out brightness level.
module sprite_palette_lut #(
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned CH_W       = 4,
  parameter int unsigned NUM_PAL    = 4,
  parameter int unsigned TRANSP_IDX = 0,
  parameter int unsigned FADE_DIV   = 2,
  localparam int unsigned PAL_W     = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              pix_valid,
  input  logic [PAL_W-1:0]  pix_pal,
  input  logic [IDX_W-1:0]  pix_idx,
  output logic              out_valid,
  output logic [CH_W-1:0]   red,
  output logic [CH_W-1:0]   green,
  output logic [CH_W-1:0]   blue,
  output logic              transp,
  input  logic              vblank,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [PAL_W-1:0]  wr_pal,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [3*CH_W-1:0] wr_rgb,
  input  logic              fade_start,
  input  logic              fade_dir,
  output logic              fade_busy,
  output logic              fade_done
);

  localparam int unsigned Entries = 2 ** IDX_W;
  localparam int unsigned RgbW    = 3 * CH_W;
  localparam int unsigned LvlW    = CH_W + 1;
  localparam int unsigned DivW    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [LvlW-1:0] LvlFull = LvlW'(2 ** CH_W);

  typedef enum logic [0:0] {StIdle, StFading} fade_st_e;

  logic [RgbW-1:0]  r_mem [NUM_PAL][Entries];
  logic             w_wr_en;
  logic [PAL_W-1:0] w_rd_pal;

  logic [RgbW-1:0]  r_s1_rgb;
  logic             r_s1_transp, r_s1_valid;
  logic [RgbW-1:0]  w_s2_rgb, r_s2_rgb;
  logic             r_s2_transp, r_s2_valid;

  fade_st_e         r_state, w_state_d;
  logic [LvlW-1:0]  r_level, w_level_d, w_step, w_tgt_cur, w_tgt_new;
  logic             r_dir, w_dir_d;
  logic [DivW-1:0]  r_cnt, w_cnt_d;
  logic             r_done, w_done_d;

  // Out-of-range banks: writes are dropped, reads alias onto the last bank.
  assign wr_ready = vblank;
  assign w_wr_en  = wr_valid && vblank && ({1'b0, wr_pal} < (PAL_W + 1)'(NUM_PAL));
  assign w_rd_pal = ({1'b0, pix_pal} >= (PAL_W + 1)'(NUM_PAL)) ? PAL_W'(NUM_PAL - 1) : pix_pal;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned p = 0; p < NUM_PAL; p++) begin
        for (int unsigned i = 0; i < Entries; i++) begin
          r_mem[p][i] <= {3{CH_W'(i)}};
        end
      end
    end else if (w_wr_en) begin
      r_mem[wr_pal][wr_idx] <= wr_rgb;
    end
  end

  function automatic logic [CH_W-1:0] scale(input logic [CH_W-1:0] c, input logic [LvlW-1:0] l);
    logic [CH_W+LvlW-1:0] prod;
    prod = {{LvlW{1'b0}}, c} * {{CH_W{1'b0}}, l};
    return prod[CH_W +: CH_W];
  endfunction

  always_comb begin
    w_s2_rgb = '0;
    if (!r_s1_transp) begin
      w_s2_rgb = {scale(r_s1_rgb[2*CH_W +: CH_W], r_level),
                  scale(r_s1_rgb[CH_W +: CH_W], r_level),
                  scale(r_s1_rgb[0 +: CH_W], r_level)};
    end
  end

  // Both stages load every cycle; the memory read sees pre-write data.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_s1_rgb    <= '0;
      r_s1_transp <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_s2_rgb    <= '0;
      r_s2_transp <= 1'b0;
      r_s2_valid  <= 1'b0;
    end else begin
      r_s1_rgb    <= r_mem[w_rd_pal][pix_idx];
      r_s1_transp <= (pix_idx == IDX_W'(TRANSP_IDX));
      r_s1_valid  <= pix_valid;
      r_s2_rgb    <= w_s2_rgb;
      r_s2_transp <= r_s1_transp;
      r_s2_valid  <= r_s1_valid;
    end
  end

  assign w_tgt_cur = r_dir ? LvlFull : '0;
  assign w_tgt_new = fade_dir ? LvlFull : '0;
  assign w_step    = r_dir ? ((r_level == LvlFull) ? r_level : r_level + 1'b1)
                           : ((r_level == '0) ? r_level : r_level - 1'b1);

  always_comb begin
    w_state_d = r_state;
    w_level_d = r_level;
    w_dir_d   = r_dir;
    w_cnt_d   = r_cnt;
    w_done_d  = 1'b0;
    if (fade_start) begin
      w_dir_d = fade_dir;
      w_cnt_d = '0;
      if (r_level == w_tgt_new) begin
        w_state_d = StIdle;
        w_done_d  = 1'b1;
      end else begin
        w_state_d = StFading;
      end
    end else if (r_state == StFading) begin
      if (r_cnt == DivW'(FADE_DIV - 1)) begin
        w_cnt_d   = '0;
        w_level_d = w_step;
        if (w_step == w_tgt_cur) begin
          w_state_d = StIdle;
          w_done_d  = 1'b1;
        end
      end else begin
        w_cnt_d = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= StIdle;
      r_level <= LvlFull;
      r_dir   <= 1'b0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_level <= w_level_d;
      r_dir   <= w_dir_d;
      r_cnt   <= w_cnt_d;
      r_done  <= w_done_d;
    end
  end

  assign out_valid = r_s2_valid;
  assign transp    = r_s2_transp;
  assign red       = r_s2_rgb[2*CH_W +: CH_W];
  assign green     = r_s2_rgb[CH_W +: CH_W];
  assign blue      = r_s2_rgb[0 +: CH_W];
  assign fade_busy = (r_state == StFading);
  assign fade_done = r_done;

endmodule
